// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared types and constants for the HDMI stream core.
//   - FSM state and pixel-source mode encodings
//   - colour-bar palette lookup
//   - 720p / 1080p timing presets (pixels / lines)
package hdmi_pkg;

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    typedef enum logic [1:0] {
        ModeStream = 2'd0,
        ModeSolid  = 2'd1,
        ModeBars   = 2'd2,
        ModeBlack  = 2'd3
    } mode_e;

    // 1280x720 timing
    localparam int unsigned Hres720   = 1280;
    localparam int unsigned HFp720    = 110;
    localparam int unsigned HSync720  = 40;
    localparam int unsigned HBp720    = 220;
    localparam int unsigned Vres720   = 720;
    localparam int unsigned VFp720    = 5;
    localparam int unsigned VSync720  = 5;
    localparam int unsigned VBp720    = 20;

    // 1920x1080 timing
    localparam int unsigned Hres1080  = 1920;
    localparam int unsigned HFp1080   = 88;
    localparam int unsigned HSync1080 = 44;
    localparam int unsigned HBp1080   = 148;
    localparam int unsigned Vres1080  = 1080;
    localparam int unsigned VFp1080   = 4;
    localparam int unsigned VSync1080 = 5;
    localparam int unsigned VBp1080   = 36;

    // Bar order left to right: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hdmi_pixel_unpack.sv
// hdmi_pixel_unpack: combinational packed-word to 24-bit RGB conversion.
//   word_i : 32-bit packed word (RGB565 pair or xRGB8888)
//   hi_i   : RGB565 only, 1 selects the upper 16 bits, 0 the lower 16 bits
//   rgb_o  : {R, G, B}, 8 bits each; RGB565 is widened by zero-fill
module hdmi_pixel_unpack #(
    parameter int unsigned NUM_BYTES_PER_PIXEL = 2
) (
    input  logic [31:0] word_i,
    input  logic        hi_i,
    output logic [23:0] rgb_o
);
    logic [15:0] half;

    always_comb begin
        half = hi_i ? word_i[31:16] : word_i[15:0];
        if (NUM_BYTES_PER_PIXEL == 4) begin
            rgb_o = word_i[23:0];
        end else begin
            rgb_o = {half[15:11], 3'b000, half[10:5], 2'b00, half[4:0], 3'b000};
        end
    end

endmodule

// File: rtl/hdmi_stream_core.sv
// hdmi_stream_core: video timing generator and pixel unpacker.
//   clock_i/reset_n_i : pixel clock, synchronous active-low reset
//   start_i           : run while high; stop takes effect at the frame wrap
//   mode_i/color_i    : pixel source (stream, solid, bars, black) and solid word
//   fifo_data_i/fifo_empty_i, read_fifo_o : show-ahead line FIFO interface
//   read_go_o/read_next_line_o/read_next_chunk_o/read_done_o : DMA handshakes
//   red_o/green_o/blue_o, hsync_o/vsync_o/ve_o : registered video, 1-cycle latency
//   underflow_o : sticky until frame wrap, frame_count_o : wrapped frame counter
module hdmi_stream_core
    import hdmi_pkg::*;
#(
    parameter int unsigned HRES                = Hres720,
    parameter int unsigned VRES                = Vres720,
    parameter int unsigned H_FP                = HFp720,
    parameter int unsigned H_SYNC              = HSync720,
    parameter int unsigned H_BP                = HBp720,
    parameter int unsigned V_FP                = VFp720,
    parameter int unsigned V_SYNC              = VSync720,
    parameter int unsigned V_BP                = VBp720,
    parameter int unsigned NUM_BYTES_PER_PIXEL = 2,
    parameter bit          HSYNC_POL           = 1'b1,
    parameter bit          VSYNC_POL           = 1'b1,
    parameter int unsigned CHUNK_WORDS         = 32
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        start_i,
    input  logic [1:0]  mode_i,
    input  logic [31:0] color_i,
    input  logic [31:0] fifo_data_i,
    input  logic        fifo_empty_i,
    output logic        read_fifo_o,
    output logic        read_go_o,
    output logic        read_next_line_o,
    output logic        read_next_chunk_o,
    output logic        read_done_o,
    output logic [7:0]  red_o,
    output logic [7:0]  green_o,
    output logic [7:0]  blue_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        ve_o,
    output logic        underflow_o,
    output logic [15:0] frame_count_o
);
    localparam int unsigned HTOTAL = HRES + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTOTAL = VRES + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW     = $clog2(HTOTAL);
    localparam int unsigned VW     = $clog2(VTOTAL);
    localparam int unsigned BarW   = (HRES >= 8) ? HRES / 8 : 1;

    localparam logic [HW-1:0] HActEnd  = HW'(HRES);
    localparam logic [HW-1:0] HSyncBeg = HW'(HRES + H_FP);
    localparam logic [HW-1:0] HSyncEnd = HW'(HRES + H_FP + H_SYNC);
    localparam logic [HW-1:0] HLast    = HW'(HTOTAL - 1);
    localparam logic [VW-1:0] VActEnd  = VW'(VRES);
    localparam logic [VW-1:0] VLastAct = VW'(VRES - 1);
    localparam logic [VW-1:0] VSyncBeg = VW'(VRES + V_FP);
    localparam logic [VW-1:0] VSyncEnd = VW'(VRES + V_FP + V_SYNC);
    localparam logic [VW-1:0] VLast    = VW'(VTOTAL - 1);

    state_e         state_q;
    mode_e          mode_q;
    logic [HW-1:0]  h_q;
    logic [VW-1:0]  v_q;
    logic           stop_q;
    logic [15:0]    hold_q;
    logic           ve_q, hs_q, vs_q, uf_q;
    logic [23:0]    rgb_q;
    logic [15:0]    frame_q;

    logic           active, wrap, stream, odd, pop, hs_act, vs_act;
    logic [HW-1:0]  word_idx;
    logic [31:0]    bar_idx;
    logic [31:0]    unpack_word;
    logic           unpack_hi;
    logic [23:0]    unpack_rgb;
    logic [23:0]    pix_d;

    assign active   = (h_q < HActEnd) && (v_q < VActEnd);
    assign wrap     = (h_q == HLast) && (v_q == VLast);
    assign stream   = (state_q == StRun) && (mode_q == ModeStream);
    // In RGB565 the odd pixel comes from the half word held at the previous pop.
    assign odd      = (NUM_BYTES_PER_PIXEL == 2) && h_q[0];
    assign pop      = stream && active && !odd;
    assign hs_act   = (h_q >= HSyncBeg) && (h_q < HSyncEnd);
    assign vs_act   = (v_q >= VSyncBeg) && (v_q < VSyncEnd);
    assign word_idx = (NUM_BYTES_PER_PIXEL == 2) ? (h_q >> 1) : h_q;
    assign bar_idx  = 32'(h_q) / BarW;

    assign read_fifo_o       = pop;
    assign read_go_o         = stream && (h_q == '0) && (v_q == VLast);
    assign read_next_line_o  = stream && (h_q == HActEnd) && (v_q < VLastAct);
    assign read_done_o       = stream && (h_q == HActEnd) && (v_q == VLastAct);
    assign read_next_chunk_o = pop && (((32'(word_idx) + 32'd1) % CHUNK_WORDS) == 32'd0);

    always_comb begin
        unpack_word = color_i;
        unpack_hi   = !odd;
        if (mode_q == ModeStream) begin
            unpack_word = odd ? {16'h0000, hold_q} : fifo_data_i;
        end
    end

    hdmi_pixel_unpack #(
        .NUM_BYTES_PER_PIXEL(NUM_BYTES_PER_PIXEL)
    ) u_unpack (
        .word_i(unpack_word),
        .hi_i  (unpack_hi),
        .rgb_o (unpack_rgb)
    );

    always_comb begin
        pix_d = 24'h000000;
        if (active) begin
            unique case (mode_q)
                ModeStream: pix_d = (pop && fifo_empty_i) ? 24'h000000 : unpack_rgb;
                ModeSolid:  pix_d = unpack_rgb;
                ModeBars:   pix_d = (bar_idx < 32'd8) ? bar_color(bar_idx[2:0]) : 24'h000000;
                ModeBlack:  pix_d = 24'h000000;
                default:    pix_d = 24'h000000;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
            mode_q  <= ModeStream;
            h_q     <= '0;
            v_q     <= '0;
            stop_q  <= 1'b0;
            hold_q  <= 16'h0000;
            ve_q    <= 1'b0;
            hs_q    <= ~HSYNC_POL;
            vs_q    <= ~VSYNC_POL;
            rgb_q   <= 24'h000000;
            uf_q    <= 1'b0;
            frame_q <= 16'h0000;
        end else begin
            unique case (state_q)
                StIdle: begin
                    ve_q  <= 1'b0;
                    hs_q  <= ~HSYNC_POL;
                    vs_q  <= ~VSYNC_POL;
                    rgb_q <= 24'h000000;
                    if (start_i) begin
                        state_q <= StRun;
                        mode_q  <= mode_e'(mode_i);
                        h_q     <= '0;
                        v_q     <= VLast;  // pre-frame line gives the DMA a line of lead time
                        stop_q  <= 1'b0;
                    end
                end
                StRun: begin
                    ve_q  <= active;
                    hs_q  <= hs_act ? HSYNC_POL : ~HSYNC_POL;
                    vs_q  <= vs_act ? VSYNC_POL : ~VSYNC_POL;
                    rgb_q <= pix_d;
                    uf_q  <= uf_q | (pop & fifo_empty_i);
                    if (pop) begin
                        hold_q <= fifo_empty_i ? 16'h0000 : fifo_data_i[15:0];
                    end
                    if (!start_i) begin
                        stop_q <= 1'b1;
                    end
                    if (h_q == HLast) begin
                        h_q <= '0;
                        v_q <= (v_q == VLast) ? '0 : v_q + VW'(1);
                    end else begin
                        h_q <= h_q + HW'(1);
                    end
                    if (wrap) begin
                        frame_q <= frame_q + 16'd1;
                        uf_q    <= 1'b0;
                        mode_q  <= mode_e'(mode_i);
                        if (stop_q || !start_i) begin
                            state_q <= StIdle;
                            stop_q  <= 1'b0;
                            ve_q    <= 1'b0;
                            hs_q    <= ~HSYNC_POL;
                            vs_q    <= ~VSYNC_POL;
                            rgb_q   <= 24'h000000;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign red_o         = rgb_q[23:16];
    assign green_o       = rgb_q[15:8];
    assign blue_o        = rgb_q[7:0];
    assign hsync_o       = hs_q;
    assign vsync_o       = vs_q;
    assign ve_o          = ve_q;
    assign underflow_o   = uf_q;
    assign frame_count_o = frame_q;

endmodule

// File: doc/hdmi_stream_core.md
Name: hdmi_stream_core

Overview:
Parametrised HDMI/DVI video timing generator and pixel unpacker, the successor to hdmi_core. It produces hsync, vsync and ve, and pulls packed pixel words from a show-ahead line FIFO. It issues read_go, read_next_line, read_next_chunk and read_done to the upstream frame-buffer DMA. It adds selectable resolution/porches, sync polarity, 2- or 4-byte pixels, internal test patterns, underflow detection and a clean stop at the frame boundary.

Parameters:
HRES, 1280, active pixels per line
VRES, 720, active lines per frame
H_FP / H_SYNC / H_BP, 110 / 40 / 220, horizontal porch and sync widths in pixels
V_FP / V_SYNC / V_BP, 5 / 5 / 20, vertical porch and sync widths in lines
NUM_BYTES_PER_PIXEL, 2, legal values 2 (RGB565, two pixels per word) or 4 (xRGB8888, one pixel per word)
HSYNC_POL / VSYNC_POL, 1 / 1, active level of each sync output
CHUNK_WORDS, 32, FIFO words per read_next_chunk pulse

Ports:
clock  in  1  single clock, pixel rate
reset_n  in  1  synchronous, active-low reset
start  in  1  level; run while high
mode  in  2  0 stream, 1 solid color, 2 color bars, 3 black
color  in  32  solid-color word, same packing as fifo_data
fifo_data  in  32  show-ahead FIFO head word
fifo_empty  in  1  FIFO empty flag
read_fifo  out  1  pop strobe, combinational from counters
read_go  out  1  one-cycle pulse, frame fetch start
read_next_line  out  1  one-cycle pulse
read_next_chunk  out  1  one-cycle pulse
read_done  out  1  one-cycle pulse, last line fetched
red / green / blue  out  8 each  pixel outputs
hsync / vsync / ve  out  1 each  timing outputs
underflow  out  1  sticky per frame
frame_count  out  16  completed frames, wraps

Behaviour:
- HTOTAL = HRES+H_FP+H_SYNC+H_BP; VTOTAL likewise. Line order: active, FP, sync, BP.
- h_count runs 0..HTOTAL-1. v_count increments when h wraps and runs 0..VTOTAL-1.
- Reset (reset_n=0 at an edge): counters 0, state IDLE, all outputs 0, hsync=!HSYNC_POL, vsync=!VSYNC_POL, frame_count=0, underflow=0. Reset wins over every other input.
- FSM IDLE -> RUN:
  - Transition on the cycle start=1 is sampled. Counters begin at h=0, v=VTOTAL-1 (pre-frame line).
  - While in RUN, start=0 is noted. At the next frame wrap (h=HTOTAL-1, v=VTOTAL-1) the FSM returns to IDLE and outputs go to reset levels.
  - mode is latched at each frame wrap and at IDLE->RUN.
- Active region: h<HRES and v<VRES.
- Outputs are registered. ve, hsync, vsync and RGB for counter position c appear at cycle c+1 (1-cycle latency, mutually aligned).
- hsync is active for HRES+H_FP <= h < HRES+H_FP+H_SYNC. vsync is active for lines VRES+V_FP <= v < VRES+V_FP+V_SYNC.
- Stream mode fetch:
  - NUM_BYTES_PER_PIXEL=2: read_fifo=1 on even active pixels. The upper 16 bits form the first pixel and are displayed at the even position; the lower 16 bits are held for the odd position.
  - NUM_BYTES_PER_PIXEL=4: read_fifo=1 on every active pixel, using bits 23:0.
  - RGB565 expands by zero-fill: R={r5,000}, G={g6,00}, B={b5,000}.
- Underflow: if read_fifo=1 while fifo_empty=1, the output pixel is 000000 and underflow is set. underflow clears at the frame wrap. Pixel counting never stalls.
- Handshakes (stream mode only):
  - read_go at h=0, v=VTOTAL-1.
  - read_next_chunk on the cycle the CHUNK_WORDS-th, 2*CHUNK_WORDS-th, ... word of a line is popped.
  - read_next_line at h=HRES for v<VRES-1; read_done at h=HRES, v=VRES-1.
- Modes 1-3 issue no reads and no handshakes; ve and syncs are unchanged.
  - Mode 1 unpacks color exactly as stream mode unpacks fifo_data.
  - Mode 2: 8 bars of HRES/8 pixels in order white, yellow, cyan, green, magenta, red, blue, black. Remainder pixels are black.
  - Mode 3: all pixels 000000.
- frame_count increments at each frame wrap while in RUN.

Decomposition:
- hdmi_pkg holds: mode encodings, bar color constants, and 720p/1080p timing preset constants.
- Sub-module hdmi_pixel_unpack: combinational 32-bit word + half-select + NUM_BYTES_PER_PIXEL -> 24-bit RGB. It is shared by the stream and solid-color paths.

Test Plan:
Common small parameters: HRES=8, VRES=2, H_FP=H_SYNC=H_BP=2, V_FP=V_SYNC=V_BP=1 (HTOTAL=14, VTOTAL=5).
1. Reset, start=1, mode=1, color=F102A39E, 2 bytes/pixel -> active pixels alternate F0/20/10 and A0/70/F0. No read_fifo.
2. Mode 0, FIFO never empty -> exactly 4 pops per line and 8 per frame. read_go once, read_next_line once, read_done once per frame. hsync active for h=10..11. ve high for 8 cycles per active line.
3. Mode 0, fifo_empty forced on the 3rd pop -> those two pixels are 000000. underflow=1 until the frame wrap, then 0.
4. Mode 2, HRES=16 -> two pixels per bar: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
5. Drop start mid-frame -> the frame completes, frame_count increments once, then syncs go inactive and no further pops occur. reset_n=0 mid-line -> all outputs are at reset values on the next cycle.
6. NUM_BYTES_PER_PIXEL=4, CHUNK_WORDS=4 -> 8 pops per line, read_next_chunk on the 4th and 8th pop. Sync polarities 0 -> inverted hsync/vsync.
